cpu_controller: RTL and testbench

- Control-side counterpart of the simpleRISC datapath: fetches 16-bit instructions from memory, decodes them, and sequences the datapath control bus.
- Datapath controls driven: vsel, readnum/writenum, write, loada/b/c/s, asel/bsel, shift, ALUop, sximm5/sximm8.
- Owns the program counter (PC), instruction register (IR) and data-address register.
- Talks to memory over a one-outstanding-request command/ready handshake.
- Sits between the instruction/data memory and the datapath in the CPU top level.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/instr_decoder.sv | 30 +++
 rtl/cpu_controller.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the simpleRISC control unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IF1,
        S_UPC,
        S_DEC,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WRC,
        S_AIMM,
        S_ADDR,
        S_RD,
        S_WRM,
        S_PASS,
        S_WR,
        S_HALT
    } state_e;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_MDATA = 4'b0001;
    localparam logic [3:0] VSEL_IMM8  = 4'b0010;
    localparam logic [3:0] VSEL_PC    = 4'b0100;
    localparam logic [3:0] VSEL_C     = 4'b1000;

    // True for every {opcode,op} pair the controller knows how to sequence.
    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OPC_MOV:  ok = (op == OP_MOV_REG) || (op == OP_MOV_IMM);
            OPC_ALU:  ok = 1'b1;
            OPC_LDR:  ok = (op == 2'b00);
            OPC_STR:  ok = (op == 2'b00);
            OPC_HALT: ok = (op == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Splits the instruction register into fields and sign-extended immediates.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        legal
);

    // Pure field extraction; no state lives here.
    always_comb begin
        opcode = ir[15:13];
        op     = ir[12:11];
        rn     = ir[10:8];
        rd     = ir[7:5];
        sh     = ir[4:3];
        rm     = ir[2:0];
        sximm5 = {{11{ir[4]}}, ir[4:0]};
        sximm8 = {{8{ir[7]}}, ir[7:0]};
        legal  = is_legal(ir[15:13], ir[12:11]);
    end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/sequence control unit driving the simpleRISC datapath.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned         PC_W     = 9,
    parameter logic [PC_W-1:0]     PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [1:0]      mem_cmd,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ready,
    input  logic [15:0]     datapath_out,
    output logic [15:0]     mdata,
    output logic [3:0]      vsel,
    output logic [2:0]      writenum,
    output logic [2:0]      readnum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [15:0]     mdata_q, mdata_d;
    logic            illegal_q, illegal_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       legal;
    logic       is_str, is_mem, is_cmp;

    instr_decoder u_dec (
        .ir     (ir_q),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm5 (sximm5),
        .sximm8 (sximm8),
        .legal  (legal)
    );

    assign is_str = (opcode == OPC_STR);
    assign is_mem = (opcode == OPC_LDR) || is_str;
    assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);

    // Next-state and register updates for the instruction sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_d    = addr_q;
        mdata_d   = mdata_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IF1: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_UPC;
                end
            end
            S_UPC: begin
                pc_d    = pc_q + PC_ONE;
                state_d = S_DEC;
            end
            S_DEC: begin
                if (!legal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else if (opcode == OPC_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
                    state_d = S_WIMM;
                end else if (opcode == OPC_MOV || op == OP_MVN) begin
                    state_d = S_GETB;
                end else begin
                    state_d = S_GETA;
                end
            end
            S_GETA: state_d = is_mem ? S_AIMM : S_GETB;
            S_GETB: state_d = is_str ? S_PASS : S_ALU;
            S_ALU:  state_d = is_cmp ? S_IF1 : S_WRC;
            S_AIMM: state_d = S_ADDR;
            S_ADDR: begin
                addr_d  = datapath_out[PC_W-1:0];
                state_d = is_str ? S_GETB : S_RD;
            end
            S_RD: begin
                if (mem_ready) begin
                    mdata_d = mem_rdata;
                    state_d = S_WRM;
                end
            end
            S_PASS: state_d = S_WR;
            S_WR: begin
                if (mem_ready) begin
                    state_d = S_IF1;
                end
            end
            S_WIMM, S_WRC, S_WRM: state_d = S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF1;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF1;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            addr_q    <= '0;
            mdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            mdata_q   <= mdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the control bus; held quiet while reset is asserted.
    always_comb begin
        mem_cmd  = MEM_NONE;
        vsel     = VSEL_MDATA;
        writenum = 3'd0;
        readnum  = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_IF1: mem_cmd = MEM_READ;
                S_WIMM: begin
                    vsel     = VSEL_IMM8;
                    writenum = rn;
                    write    = 1'b1;
                end
                S_GETA: begin
                    readnum = rn;
                    loada   = 1'b1;
                end
                S_GETB: begin
                    readnum = is_str ? rd : rm;
                    loadb   = 1'b1;
                end
                S_ALU: begin
                    asel  = (opcode == OPC_MOV);
                    shift = sh;
                    ALUop = (opcode == OPC_MOV) ? 2'b00 : op;
                    loadc = 1'b1;
                    loads = is_cmp;
                end
                S_WRC: begin
                    vsel     = VSEL_C;
                    writenum = rd;
                    write    = 1'b1;
                end
                S_AIMM: begin
                    bsel  = 1'b1;
                    loadc = 1'b1;
                end
                S_RD: mem_cmd = MEM_READ;
                S_WRM: begin
                    vsel     = VSEL_MDATA;
                    writenum = rd;
                    write    = 1'b1;
                end
                S_PASS: begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                end
                S_WR: mem_cmd = MEM_WRITE;
                default: ;
            endcase
        end
    end

    assign mem_addr  = (state_q == S_IF1) ? pc_q : addr_q;
    assign mem_wdata = datapath_out;
    assign mdata     = mdata_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected control-bus beats are queued
// with the cycle they should appear in, and a monitor pops one per active beat.
module tb_cpu_controller;

    localparam logic [6:0] ST_WRITE = 7'b1000000;
    localparam logic [6:0] ST_LOADA = 7'b0100000;
    localparam logic [6:0] ST_LOADB = 7'b0010000;
    localparam logic [6:0] ST_LOADC = 7'b0001000;
    localparam logic [6:0] ST_LOADS = 7'b0000100;
    localparam logic [6:0] ST_ASEL  = 7'b0000010;
    localparam logic [6:0] ST_BSEL  = 7'b0000001;

    localparam int C_RN  = 1;
    localparam int C_WN  = 2;
    localparam int C_ALU = 4;

    localparam int X_NONE  = 0;
    localparam int X_IMM8  = 1;
    localparam int X_WDATA = 2;
    localparam int X_MDATA = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] datapath_out;
    logic [15:0] mdata;
    logic [3:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;
    logic [8:0]  pc;
    logic        halted, illegal;

    logic [15:0] rom [0:511];

    typedef struct {
        int         cyc;
        logic [1:0] cmd;
        logic [8:0] addr;
        logic [6:0] strb;
        logic [3:0] vsel;
        logic [2:0] rn;
        logic [2:0] wn;
        logic [1:0] sh;
        logic [1:0] alu;
        int         care;
        int         xsel;
        logic [15:0] xval;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;
    logic fire;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = rom[mem_addr];
    assign fire = (mem_cmd != 2'b00) || write || loada || loadb || loadc || loads;

    cpu_controller #(.PC_W(9), .PC_RESET(9'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_cmd      (mem_cmd),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .datapath_out (datapath_out),
        .mdata        (mdata),
        .vsel         (vsel),
        .writenum     (writenum),
        .readnum      (readnum),
        .write        (write),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .loads        (loads),
        .asel         (asel),
        .bsel         (bsel),
        .shift        (shift),
        .ALUop        (ALUop),
        .sximm8       (sximm8),
        .sximm5       (sximm5),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal)
    );

    task automatic expectStep(input int c, input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [6:0] strb, input logic [3:0] vs,
                              input logic [2:0] rn, input logic [2:0] wn,
                              input logic [1:0] sh, input logic [1:0] alu,
                              input int care, input int xsel, input logic [15:0] xval);
        exp_t e;
        e.cyc = c; e.cmd = cmd; e.addr = addr; e.strb = strb; e.vsel = vs;
        e.rn = rn; e.wn = wn; e.sh = sh; e.alu = alu;
        e.care = care; e.xsel = xsel; e.xval = xval;
        sbq.push_back(e);
    endtask

    task automatic expectRead(input int c, input logic [8:0] addr);
        expectStep(c, 2'b01, addr, 7'b0, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, 0, X_NONE, 16'h0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0]  strb_a;
        logic [15:0] x_a;
        logic        ok;
        strb_a = {write, loada, loadb, loadc, loads, asel, bsel};
        case (e.xsel)
            X_IMM8:  x_a = sximm8;
            X_WDATA: x_a = mem_wdata;
            X_MDATA: x_a = mdata;
            default: x_a = 16'h0;
        endcase
        ok = (cyc == e.cyc) && (mem_cmd === e.cmd) && (strb_a === e.strb) && (vsel === e.vsel);
        if (e.cmd != 2'b00 && mem_addr !== e.addr) ok = 1'b0;
        if ((e.care & C_RN) != 0 && readnum !== e.rn) ok = 1'b0;
        if ((e.care & C_WN) != 0 && writenum !== e.wn) ok = 1'b0;
        if ((e.care & C_ALU) != 0 && (shift !== e.sh || ALUop !== e.alu)) ok = 1'b0;
        if (e.xsel != X_NONE && x_a !== e.xval) ok = 1'b0;
        nChecks++;
        if (!ok) begin
            nFail++;
            $display("[TB] FAIL step got cyc=%0d cmd=%b addr=%h strb=%b vsel=%b rn=%0d wn=%0d sh=%b alu=%b x=%h | want cyc=%0d cmd=%b addr=%h strb=%b vsel=%b rn=%0d wn=%0d sh=%b alu=%b x=%h",
                     cyc, mem_cmd, mem_addr, strb_a, vsel, readnum, writenum, shift, ALUop, x_a,
                     e.cyc, e.cmd, e.addr, e.strb, e.vsel, e.rn, e.wn, e.sh, e.alu, e.xval);
        end
    endtask

    task automatic checkValue(input string name, input logic [15:0] got, input logic [15:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dp, input logic rdy);
        datapath_out = dp;
        mem_ready    = rdy;
    endtask

    task automatic atCycle(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic releaseReset(output int b);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        b = cyc;
    endtask

    // Monitor: every active control beat must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && fire) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_beat cyc=%0d cmd=%b addr=%h write=%b loadc=%b want none",
                         cyc, mem_cmd, mem_addr, write, loadc);
            end else begin
                checkOutput(sbq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b, b1, b2, b3, b4, b5;

        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        rom[0]     = 16'hD0FD;   // MOV R0,#-3
        rom[1]     = 16'hA148;   // ADD R2,R1,R0,LSL#1
        rom[2]     = 16'hA900;   // CMP R1,R0
        rom[3]     = 16'h6162;   // LDR R3,[R1,#2]
        rom[4]     = 16'h8162;   // STR R3,[R1,#2]
        rom[5]     = 16'h0000;   // undefined
        rom[9'h44] = 16'hBEEF;
        applyStimulus(16'h0044, 1'b1);

        // Reset state
        #1 rst_n = 1'b0;
        #3;
        checkValue("reset_mem_cmd", {14'd0, mem_cmd}, 16'd0);
        checkValue("reset_write", {15'd0, write}, 16'd0);
        checkValue("reset_halted", {15'd0, halted}, 16'd0);
        checkValue("reset_illegal", {15'd0, illegal}, 16'd0);
        checkValue("reset_pc", {7'd0, pc}, 16'd0);
        checkValue("reset_mdata", mdata, 16'd0);
        releaseReset(b);

        b1 = b + 4; b2 = b1 + 7; b3 = b2 + 6; b4 = b3 + 11; b5 = b4 + 9;
        // MOV R0,#-3
        expectRead(b, 9'd0);
        expectStep(b + 3, 2'b00, 9'd0, ST_WRITE, 4'b0010, 3'd0, 3'd0, 2'b00, 2'b00, C_WN, X_IMM8, 16'hFFFD);
        // ADD R2,R1,R0,LSL#1
        expectRead(b1, 9'd1);
        expectStep(b1 + 3, 2'b00, 9'd0, ST_LOADA, 4'b0001, 3'd1, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b1 + 4, 2'b00, 9'd0, ST_LOADB, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b1 + 5, 2'b00, 9'd0, ST_LOADC, 4'b0001, 3'd0, 3'd0, 2'b01, 2'b00, C_ALU, X_NONE, 16'h0);
        expectStep(b1 + 6, 2'b00, 9'd0, ST_WRITE, 4'b1000, 3'd0, 3'd2, 2'b00, 2'b00, C_WN, X_NONE, 16'h0);
        // CMP R1,R0
        expectRead(b2, 9'd2);
        expectStep(b2 + 3, 2'b00, 9'd0, ST_LOADA, 4'b0001, 3'd1, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b2 + 4, 2'b00, 9'd0, ST_LOADB, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b2 + 5, 2'b00, 9'd0, ST_LOADC | ST_LOADS, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b01, C_ALU, X_NONE, 16'h0);
        // LDR R3,[R1,#2] with a three-cycle memory stall
        expectRead(b3, 9'd3);
        expectStep(b3 + 3, 2'b00, 9'd0, ST_LOADA, 4'b0001, 3'd1, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b3 + 4, 2'b00, 9'd0, ST_LOADC | ST_BSEL, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_ALU, X_NONE, 16'h0);
        for (int i = 6; i <= 9; i++) expectRead(b3 + i, 9'h044);
        expectStep(b3 + 10, 2'b00, 9'd0, ST_WRITE, 4'b0001, 3'd0, 3'd3, 2'b00, 2'b00, C_WN, X_MDATA, 16'hBEEF);
        // STR R3,[R1,#2]
        expectRead(b4, 9'd4);
        expectStep(b4 + 3, 2'b00, 9'd0, ST_LOADA, 4'b0001, 3'd1, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b4 + 4, 2'b00, 9'd0, ST_LOADC | ST_BSEL, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_ALU, X_NONE, 16'h0);
        expectStep(b4 + 6, 2'b00, 9'd0, ST_LOADB, 4'b0001, 3'd3, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b4 + 7, 2'b00, 9'd0, ST_LOADC | ST_ASEL, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_ALU, X_NONE, 16'h0);
        expectStep(b4 + 8, 2'b10, 9'h044, 7'b0, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, 0, X_WDATA, 16'h5A5A);
        // Undefined opcode
        expectRead(b5, 9'd5);

        atCycle(b + 3);
        checkValue("pc_after_first_fetch", {7'd0, pc}, 16'd1);
        atCycle(b3 + 5);
        applyStimulus(16'h0044, 1'b0);
        atCycle(b3 + 9);
        applyStimulus(16'h0044, 1'b1);
        atCycle(b4 + 6);
        applyStimulus(16'h5A5A, 1'b1);
        atCycle(b5 + 5);
        checkValue("illegal_halted", {15'd0, halted}, 16'd1);
        checkValue("illegal_flag", {15'd0, illegal}, 16'd1);
        checkValue("illegal_pc", {7'd0, pc}, 16'd6);
        atCycle(b5 + 12);
        checkValue("illegal_absorbing", {15'd0, halted}, 16'd1);
        checkValue("program_drained", sbq.size(), 16'd0);

        // HALT opcode: no illegal flag, no further memory traffic
        rst_n = 1'b0;
        rom[0] = 16'hE000;
        applyStimulus(16'h0044, 1'b1);
        releaseReset(b);
        expectRead(b, 9'd0);
        atCycle(b + 4);
        checkValue("halt_halted", {15'd0, halted}, 16'd1);
        checkValue("halt_illegal", {15'd0, illegal}, 16'd0);
        atCycle(b + 10);
        checkValue("halt_drained", sbq.size(), 16'd0);

        // Reset asserted while LDR waits in RD
        rst_n = 1'b0;
        rom[0] = 16'h6162;
        releaseReset(b);
        expectRead(b, 9'd0);
        expectStep(b + 3, 2'b00, 9'd0, ST_LOADA, 4'b0001, 3'd1, 3'd0, 2'b00, 2'b00, C_RN, X_NONE, 16'h0);
        expectStep(b + 4, 2'b00, 9'd0, ST_LOADC | ST_BSEL, 4'b0001, 3'd0, 3'd0, 2'b00, 2'b00, C_ALU, X_NONE, 16'h0);
        expectRead(b + 6, 9'h044);
        expectRead(b + 7, 9'h044);
        atCycle(b + 5);
        applyStimulus(16'h0044, 1'b0);
        atCycle(b + 7);
        rst_n = 1'b0;
        #1;
        checkValue("abort_mem_cmd", {14'd0, mem_cmd}, 16'd0);
        checkValue("abort_pc", {7'd0, pc}, 16'd0);
        checkValue("abort_write", {15'd0, write}, 16'd0);
        applyStimulus(16'h0044, 1'b1);
        checkValue("abort_drained", sbq.size(), 16'd0);

        // PC wrap: 513 back-to-back MOV immediates
        for (int i = 0; i < 512; i++) rom[i] = 16'hD0FD;
        releaseReset(b);
        for (int k = 0; k <= 512; k++) begin
            expectRead(b + 4 * k, 9'(k % 512));
            expectStep(b + 4 * k + 3, 2'b00, 9'd0, ST_WRITE, 4'b0010, 3'd0, 3'd0, 2'b00, 2'b00, C_WN, X_IMM8, 16'hFFFD);
        end
        atCycle(b + 511 * 4 + 2);
        checkValue("pc_wrap", {7'd0, pc}, 16'd0);
        atCycle(b + 513 * 4 - 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkValue("wrap_drained", sbq.size(), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
